dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter and sequencer in front of the single-port 4096-word data memory (DM). It accepts load/store requests from two masters, m0 (CPU MEM stage) and m1 (debug/DMA loader), and grants one access per two clock cycles. It drives the DM write-enable, address, write-data and pc ports, and returns read data with an ack pulse. It also screens out misaligned and out-of-range addresses so they never reach the DM.

## Interface
- Parameters:
- ADDR_LIMIT, 32'h0000_4000: first byte address outside the DM (4096 words).
- Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request; held high until the matching ack
- m0_we, m1_we  in  1  1 = store, 0 = load; stable while req high
- m0_addr, m1_addr  in  32  byte address; stable while req high
- m0_wd, m1_wd  in  32  store data; stable while req high
- m0_pc, m1_pc  in  32  pc of the requesting instruction, forwarded for the DM store log
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid only with ack; 1 = access rejected
- m0_rd, m1_rd  out  32  load data, valid only with ack
- dm_we  out  1  DM write enable
- dm_a, dm_wd, dm_pc  out  32  DM address, write data and pc
- dm_rd  in  32  DM combinational read data

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: one DM access in progress.
- Registers: sel_q (winner), we_q, a_q, wd_q, pc_q, err_q, last_q (last granted master).
- IDLE, with any req high:
  - choose the winner;
  - latch that master's we/addr/wd/pc into the _q registers;
  - set err_q = (addr[1:0] != 0) | (addr >= ADDR_LIMIT), using an unsigned compare;
  - go to ACCESS.
- IDLE, with no req high: stay in IDLE.
- ACCESS: the controller performs the access for exactly one cycle, then unconditionally returns to IDLE.
- Outputs during ACCESS:
  - dm_a = a_q, dm_wd = wd_q, dm_pc = pc_q;
  - dm_we = we_q & ~err_q & ~reset;
  - ack of the selected master = 1, and its err = err_q;
  - its rd = dm_rd when we_q = 0 and err_q = 0, otherwise 0.
- Outputs outside ACCESS:
  - dm_we = 0;
  - all acks, errs and rd outputs are 0;
  - dm_a, dm_wd and dm_pc keep the _q values (don't-care to DM).
- Winner selection when both req are high: see Configuration. When only one req is high, that master wins.
- last_q updates to the winner on every IDLE→ACCESS transition.
- An erroneous store never writes DM and never produces a DM log line. An erroneous load returns rd = 0.
- Requester contract:
  - drop req, or present a new request, in the cycle after ack;
  - a req still high in IDLE is treated as a new request.
- Reset values:
  - state = IDLE, last_q = 1 (so m0 wins the first tie);
  - sel_q = 0, all _q data registers = 0, err_q = 0;
  - all outputs 0.

## Timing
- Latency: a request first seen high in IDLE at edge N is acked during cycle N+1. The store commits at edge N+2.
- Throughput: one access per 2 cycles. Back-to-back requests from the same master alternate IDLE/ACCESS.
- Load data is combinational from DM through rd in the ACCESS cycle.
- A store in ACCESS followed by a load to the same address sees the new data, because the load's ACCESS is at least 2 cycles later.
- Reset asserted during ACCESS:
  - dm_we is forced 0 that cycle;
  - ack is still visible combinationally but is meaningless; masters ignore ack while reset is high;
  - next state = IDLE.
- A req that changes during ACCESS is ignored until IDLE.
- A req present in the cycle reset deasserts is arbitrated normally at the next edge.

## Configuration
- DM_ARB_RR_EN defined: round-robin on ties. The winner is the master other than last_q.
- DM_ARB_RR_EN undefined: fixed priority. m0 always wins ties; last_q is still maintained but has no effect on arbitration.

## Test plan
- Reset, then m0 store: m0_req=1, we=1, addr=32'h10, wd=32'hDEAD_BEEF.
  - Next cycle: dm_we=1, dm_a=32'h10, m0_ack=1, m0_err=0.
  - Following cycle: state IDLE, dm_we=0.
- m1 load from 32'h10 after that store: m1_ack=1 two cycles after req, m1_rd=32'hDEAD_BEEF.
- Both masters hold loads continuously for 8 cycles:
  - with DM_ARB_RR_EN: acks alternate m0, m1, m0, m1 on cycles 1, 3, 5, 7;
  - without it: only m0 is acked, on cycles 1, 3, 5, 7.
- m0 store to 32'h12 (misaligned), then m1 store to 32'h4000 (out of range):
  - each gets ack=1, err=1;
  - dm_we stays 0 throughout;
  - a subsequent load of 32'h10 still returns the prior data.
- Reset asserted in the ACCESS cycle of a store to 32'h20 with wd=1: dm_we=0 that cycle; next cycle IDLE; a load of 32'h20 returns 0.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter/sequencer in front of the single-port DM.
// Define DM_ARB_RR_EN for round-robin tie-break; default is fixed m0 priority.
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m1_wd,
  input  logic [31:0] m0_pc,
  input  logic [31:0] m1_pc,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rd,
  output logic [31:0] m1_rd,
  output logic        dm_we,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

`ifdef DM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q;
  logic        sel_q, we_q, err_q, last_q;
  logic [31:0] a_q, wd_q, pc_q;

  logic        any_req;
  logic        sel_d, we_d, err_d;
  logic [31:0] a_d, wd_d, pc_d;

  // Pick the winner and mux its request fields; ties go to m0 unless
  // round-robin is enabled, then to the master not granted last.
  always_comb begin
    any_req = m0_req | m1_req;
    sel_d   = m1_req & (~m0_req | (RR_EN & ~last_q));
    we_d    = sel_d ? m1_we   : m0_we;
    a_d     = sel_d ? m1_addr : m0_addr;
    wd_d    = sel_d ? m1_wd   : m0_wd;
    pc_d    = sel_d ? m1_pc   : m0_pc;
    err_d   = (a_d[1:0] != 2'b00) | (a_d >= ADDR_LIMIT);
  end

  // Two-state sequencer: latch a request in IDLE, spend one cycle in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      wd_q    <= '0;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= ACCESS;
            sel_q   <= sel_d;
            we_q    <= we_d;
            err_q   <= err_d;
            last_q  <= sel_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            pc_q    <= pc_d;
          end
        end
        ACCESS: state_q <= IDLE;
      endcase
    end
  end

  // Drive DM and master responses from the latched access.
  always_comb begin
    logic acc;
    logic ok_ld;
    acc    = (state_q == ACCESS);
    ok_ld  = acc & ~we_q & ~err_q;
    dm_a   = a_q;
    dm_wd  = wd_q;
    dm_pc  = pc_q;
    dm_we  = acc & we_q & ~err_q & ~reset;
    m0_ack = acc & ~sel_q;
    m1_ack = acc & sel_q;
    m0_err = acc & ~sel_q & err_q;
    m1_err = acc & sel_q & err_q;
    m0_rd  = (ok_ld & ~sel_q) ? dm_rd : 32'h0;
    m1_rd  = (ok_ld & sel_q) ? dm_rd : 32'h0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: transaction-level model plus directed vectors for dm_arbiter.
// Build with +define+DM_ARB_RR_EN to exercise the round-robin variant.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd, m0_pc, m1_pc;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        dm_we;
  logic [31:0] dm_a, dm_wd, dm_pc, dm_rd;

  int ncmp = 0;
  int nbad = 0;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m0_pc(m0_pc), .m1_pc(m1_pc),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_err(m0_err), .m1_err(m1_err),
    .m0_rd(m0_rd), .m1_rd(m1_rd),
    .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // data memory seen by the DUT
  logic [31:0] mem [4096];
  assign dm_rd = mem[dm_a[13:2]];
  always @(posedge clk) if (dm_we) mem[dm_a[13:2]] <= dm_wd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // transaction model: one pending access, golden memory
  logic [31:0] gold [4096];
  bit          busy = 0;
  bit          e_m, e_we, e_err;
  bit          last = 1;
  logic [31:0] e_a = 0, e_wd = 0, e_pc = 0;
`ifdef DM_ARB_RR_EN
  localparam bit RR = 1;
`else
  localparam bit RR = 0;
`endif

  always @(posedge clk) begin
    bit w;
    if (busy && e_we && !e_err && !reset) gold[e_a[13:2]] = e_wd;
    if (reset) begin
      busy = 0; last = 1; e_m = 0; e_we = 0; e_err = 0;
      e_a = 0; e_wd = 0; e_pc = 0;
    end else if (busy) begin
      busy = 0;
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) w = RR ? !last : 1'b0;
      else w = m1_req;
      e_m   = w;
      e_we  = w ? m1_we : m0_we;
      e_a   = w ? m1_addr : m0_addr;
      e_wd  = w ? m1_wd : m0_wd;
      e_pc  = w ? m1_pc : m0_pc;
      e_err = (e_a % 4 != 0) || (e_a >= 32'h4000);
      last  = w;
      busy  = 1;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic [31:0] erd;
    erd = (busy && !e_we && !e_err) ? gold[e_a[13:2]] : 32'h0;
    chk("m0_ack", {31'b0, m0_ack}, {31'b0, busy && !e_m});
    chk("m1_ack", {31'b0, m1_ack}, {31'b0, busy && e_m});
    chk("m0_err", {31'b0, m0_err}, {31'b0, busy && !e_m && e_err});
    chk("m1_err", {31'b0, m1_err}, {31'b0, busy && e_m && e_err});
    chk("m0_rd", m0_rd, e_m ? 32'h0 : erd);
    chk("m1_rd", m1_rd, e_m ? erd : 32'h0);
    chk("dm_we", {31'b0, dm_we},
        {31'b0, busy && e_we && !e_err && !reset});
    chk("dm_a", dm_a, e_a);
    chk("dm_wd", dm_wd, e_wd);
    chk("dm_pc", dm_pc, e_pc);
  end

  task automatic drive(input bit m, input bit r, input bit we,
                       input logic [31:0] a, wd, pc);
    if (m) begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wd = wd; m1_pc = pc;
    end else begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wd = wd; m0_pc = pc;
    end
  endtask

  task automatic issue(input bit m, input bit we,
                       input logic [31:0] a, wd, pc,
                       output logic ack, err, dwe,
                       output logic [31:0] rd, da);
    @(posedge clk); #2;
    drive(m, 1'b1, we, a, wd, pc);
    @(posedge clk);
    @(negedge clk);
    ack = m ? m1_ack : m0_ack;
    err = m ? m1_err : m0_err;
    rd  = m ? m1_rd : m0_rd;
    dwe = dm_we;
    da  = dm_a;
    @(posedge clk); #2;
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        ack, err, dwe;
    logic [31:0] rd, da;
    logic [7:0]  a0, a1;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h0;
      gold[i] = 32'h0;
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dm_we", {31'b0, dm_we}, 32'h0);
    chk("rst_acks", {30'b0, m1_ack, m0_ack}, 32'h0);
    chk("rst_dm_a", dm_a, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    // m0 store
    issue(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h100, ack, err, dwe, rd, da);
    chk("st_ack", {31'b0, ack}, 32'h1);
    chk("st_err", {31'b0, err}, 32'h0);
    chk("st_dm_we", {31'b0, dwe}, 32'h1);
    chk("st_dm_a", da, 32'h10);
    @(negedge clk);
    chk("st_idle_we", {31'b0, dm_we}, 32'h0);
    chk("st_idle_ack", {31'b0, m0_ack}, 32'h0);

    // m1 load of the stored word
    issue(1, 0, 32'h10, 32'h0, 32'h200, ack, err, dwe, rd, da);
    chk("ld_ack", {31'b0, ack}, 32'h1);
    chk("ld_rd", rd, 32'hDEAD_BEEF);

    // both masters hold loads for 8 cycles
    @(posedge clk); #2;
    drive(0, 1, 0, 32'h10, 32'h0, 32'h300);
    drive(1, 1, 0, 32'h14, 32'h0, 32'h400);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      a0[i] = m0_ack;
      a1[i] = m1_ack;
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
`ifdef DM_ARB_RR_EN
    chk("tie_m0", {24'b0, a0}, 32'h11);
    chk("tie_m1", {24'b0, a1}, 32'h44);
`else
    chk("tie_m0", {24'b0, a0}, 32'h55);
    chk("tie_m1", {24'b0, a1}, 32'h00);
`endif

    // misaligned and out-of-range stores
    issue(0, 1, 32'h12, 32'h1111_1111, 32'h500, ack, err, dwe, rd, da);
    chk("mis_ack", {31'b0, ack}, 32'h1);
    chk("mis_err", {31'b0, err}, 32'h1);
    chk("mis_we", {31'b0, dwe}, 32'h0);
    issue(1, 1, 32'h4000, 32'h2222_2222, 32'h600, ack, err, dwe, rd, da);
    chk("oor_ack", {31'b0, ack}, 32'h1);
    chk("oor_err", {31'b0, err}, 32'h1);
    chk("oor_we", {31'b0, dwe}, 32'h0);
    issue(0, 0, 32'h10, 32'h0, 32'h700, ack, err, dwe, rd, da);
    chk("after_err_rd", rd, 32'hDEAD_BEEF);
    issue(1, 0, 32'h0, 32'h0, 32'h710, ack, err, dwe, rd, da);
    chk("word0_rd", rd, 32'h0);
    issue(0, 0, 32'hFFFF_FFFC, 32'h0, 32'h720, ack, err, dwe, rd, da);
    chk("oor_ld_err", {31'b0, err}, 32'h1);
    chk("oor_ld_rd", rd, 32'h0);

    // reset during the ACCESS cycle of a store
    @(posedge clk); #2;
    drive(0, 1, 1, 32'h20, 32'h1, 32'h800);
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_acc_we", {31'b0, dm_we}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_idle_ack", {31'b0, m0_ack}, 32'h0);
    issue(1, 0, 32'h20, 32'h0, 32'h900, ack, err, dwe, rd, da);
    chk("rst_ld_rd", rd, 32'h0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
